imem_port_arbiter: RTL and testbench

Two-port access controller for the single-cycle core's instruction ROM. It shares the ROM's one combinational read port between the instruction-fetch stage and a debug/loader read port. Fetch has priority, and a bounded-starvation counter guarantees debug progress. Each port gets a registered, valid/ready response with alignment and range checking, and the fetch side has a flush for PC redirects.

---
 rtl/imem_port_arbiter.sv | 150 +++++++++++++++
 tb/tb_imem_port_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: shares the instruction ROM's single combinational read
// port between instruction fetch and a debug/loader port. Fetch has priority;
// a saturating starvation counter hands the port to debug after STARVE_LIMIT
// consecutive denied debug cycles. Each port owns one registered response slot.
module imem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_SIZE     = 1024,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // fetch port
  input  logic                  if_req_valid,
  input  logic [ADDR_WIDTH-1:0] if_req_addr,
  output logic                  if_req_ready,
  output logic                  if_rsp_valid,
  output logic [DATA_WIDTH-1:0] if_rsp_data,
  output logic                  if_rsp_err,
  input  logic                  if_rsp_ready,
  input  logic                  if_flush,
  // debug port
  input  logic                  dbg_req_valid,
  input  logic [ADDR_WIDTH-1:0] dbg_req_addr,
  output logic                  dbg_req_ready,
  output logic                  dbg_rsp_valid,
  output logic [DATA_WIDTH-1:0] dbg_rsp_data,
  output logic                  dbg_rsp_err,
  input  logic                  dbg_rsp_ready,
  // ROM read port
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_data
);

  // One extra bit so the ROM byte size never overflows the address width.
  localparam logic [ADDR_WIDTH:0] ROM_BYTES  = (ADDR_WIDTH+1)'(MEM_SIZE * 4);
  localparam logic [7:0]          STARVE_MAX = 8'(STARVE_LIMIT);

  // Misaligned or beyond the last ROM word.
  function automatic logic addr_err(input logic [ADDR_WIDTH-1:0] addr);
    addr_err = (addr[1:0] != 2'b00) || ({1'b0, addr} >= ROM_BYTES);
  endfunction

  logic                  if_free_s;
  logic                  dbg_free_s;
  logic                  if_elig_s;
  logic                  dbg_elig_s;
  logic                  if_gnt_s;
  logic                  dbg_gnt_s;
  logic [ADDR_WIDTH-1:0] mem_addr_s;
  logic                  cap_err_s;
  logic [DATA_WIDTH-1:0] cap_data_s;

  logic                  if_rsp_valid_r;
  logic [DATA_WIDTH-1:0] if_rsp_data_r;
  logic                  if_rsp_err_r;
  logic                  dbg_rsp_valid_r;
  logic [DATA_WIDTH-1:0] dbg_rsp_data_r;
  logic                  dbg_rsp_err_r;
  logic [7:0]            starve_cnt_r;

  // Eligibility, priority grant, ROM address mux and capture value.
  always_comb begin
    if_free_s  = ~if_rsp_valid_r | if_rsp_ready;
    dbg_free_s = ~dbg_rsp_valid_r | dbg_rsp_ready;
    if_elig_s  = 1'b0;
    dbg_elig_s = 1'b0;
    if_gnt_s   = 1'b0;
    dbg_gnt_s  = 1'b0;
    if (rst_n) begin
      if_elig_s  = if_req_valid & if_free_s & ~if_flush;
      dbg_elig_s = dbg_req_valid & dbg_free_s;
      // Debug wins only when fetch is absent or debug has starved long enough.
      dbg_gnt_s  = dbg_elig_s & (~if_elig_s | (starve_cnt_r == STARVE_MAX));
      if_gnt_s   = if_elig_s & ~dbg_gnt_s;
    end else begin
      if_elig_s  = 1'b0;
      dbg_elig_s = 1'b0;
    end
    if (dbg_gnt_s) begin
      mem_addr_s = dbg_req_addr;
    end else begin
      mem_addr_s = if_req_addr;
    end
    cap_err_s = addr_err(mem_addr_s);
    if (cap_err_s) begin
      cap_data_s = {DATA_WIDTH{1'b0}};
    end else begin
      cap_data_s = mem_data;
    end
  end

  // Fetch response slot: load on grant, clear on drain or flush, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rsp_valid_r <= 1'b0;
      if_rsp_data_r  <= {DATA_WIDTH{1'b0}};
      if_rsp_err_r   <= 1'b0;
    end else if (if_gnt_s) begin
      if_rsp_valid_r <= 1'b1;
      if_rsp_data_r  <= cap_data_s;
      if_rsp_err_r   <= cap_err_s;
    end else if (if_flush || if_rsp_ready) begin
      if_rsp_valid_r <= 1'b0;
    end else begin
      if_rsp_valid_r <= if_rsp_valid_r;
    end
  end

  // Debug response slot: load on grant, clear on drain, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbg_rsp_valid_r <= 1'b0;
      dbg_rsp_data_r  <= {DATA_WIDTH{1'b0}};
      dbg_rsp_err_r   <= 1'b0;
    end else if (dbg_gnt_s) begin
      dbg_rsp_valid_r <= 1'b1;
      dbg_rsp_data_r  <= cap_data_s;
      dbg_rsp_err_r   <= cap_err_s;
    end else if (dbg_rsp_ready) begin
      dbg_rsp_valid_r <= 1'b0;
    end else begin
      dbg_rsp_valid_r <= dbg_rsp_valid_r;
    end
  end

  // Count consecutive denied debug cycles, saturating at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_r <= 8'd0;
    end else if (!dbg_req_valid || dbg_gnt_s) begin
      starve_cnt_r <= 8'd0;
    end else if (starve_cnt_r != STARVE_MAX) begin
      starve_cnt_r <= starve_cnt_r + 8'd1;
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end

  assign if_req_ready  = if_gnt_s;
  assign dbg_req_ready = dbg_gnt_s;
  assign mem_addr      = mem_addr_s;
  assign if_rsp_valid  = if_rsp_valid_r;
  assign if_rsp_data   = if_rsp_data_r;
  assign if_rsp_err    = if_rsp_err_r;
  assign dbg_rsp_valid = dbg_rsp_valid_r;
  assign dbg_rsp_data  = dbg_rsp_data_r;
  assign dbg_rsp_err   = dbg_rsp_err_r;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed testbench for imem_port_arbiter. The ROM model returns word[i]=i
// (mem_data = mem_addr >> 2). Expected responses are queued by the stimulus
// and compared by a monitor when a response handshake completes.
module tb_imem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  logic          clk;
  logic          rst_n;
  logic          if_req_valid;
  logic [AW-1:0] if_req_addr;
  logic          if_req_ready;
  logic          if_rsp_valid;
  logic [DW-1:0] if_rsp_data;
  logic          if_rsp_err;
  logic          if_rsp_ready;
  logic          if_flush;
  logic          dbg_req_valid;
  logic [AW-1:0] dbg_req_addr;
  logic          dbg_req_ready;
  logic          dbg_rsp_valid;
  logic [DW-1:0] dbg_rsp_data;
  logic          dbg_rsp_err;
  logic          dbg_rsp_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;

  rsp_t if_q[$];
  rsp_t dbg_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  imem_port_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_SIZE(1024), .STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data), .if_rsp_err(if_rsp_err),
    .if_rsp_ready(if_rsp_ready), .if_flush(if_flush),
    .dbg_req_valid(dbg_req_valid), .dbg_req_addr(dbg_req_addr), .dbg_req_ready(dbg_req_ready),
    .dbg_rsp_valid(dbg_rsp_valid), .dbg_rsp_data(dbg_rsp_data), .dbg_rsp_err(dbg_rsp_err),
    .dbg_rsp_ready(dbg_rsp_ready),
    .mem_addr(mem_addr), .mem_data(mem_data)
  );

  // ROM model: word i holds i; out-of-range reads return nonzero on purpose.
  assign mem_data = mem_addr >> 2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare each consumed response against the scoreboard.
  always @(negedge clk) begin
    rsp_t e;
    if (rst_n && if_rsp_valid && if_rsp_ready) begin
      if (if_q.size() == 0) begin
        check("if_rsp_unexpected", 32'd1, 32'd0);
      end else begin
        e = if_q.pop_front();
        check("if_rsp_data", if_rsp_data, e.data);
        check("if_rsp_err", {31'd0, if_rsp_err}, {31'd0, e.err});
      end
    end
    if (rst_n && dbg_rsp_valid && dbg_rsp_ready) begin
      if (dbg_q.size() == 0) begin
        check("dbg_rsp_unexpected", 32'd1, 32'd0);
      end else begin
        e = dbg_q.pop_front();
        check("dbg_rsp_data", dbg_rsp_data, e.data);
        check("dbg_rsp_err", {31'd0, dbg_rsp_err}, {31'd0, e.err});
      end
    end
  end

  // Both ports request continuously: expect 4 fetch grants then 1 debug grant.
  task automatic contend(input int n, input string tag);
    logic d;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      d = ((i % 5) == 0);
      check({tag, "_if_ready"}, {31'd0, if_req_ready}, {31'd0, ~d});
      check({tag, "_dbg_ready"}, {31'd0, dbg_req_ready}, {31'd0, d});
      if (d) dbg_q.push_back('{data: 32'd16, err: 1'b0});
      else   if_q.push_back('{data: 32'd8, err: 1'b0});
    end
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    if_req_valid = 1'b1; if_req_addr = 32'h0; if_rsp_ready = 1'b0; if_flush = 1'b0;
    dbg_req_valid = 1'b1; dbg_req_addr = 32'h0; dbg_rsp_ready = 1'b0;

    // Reset state: readies low even with requests present.
    @(negedge clk);
    check("rst_if_ready", {31'd0, if_req_ready}, 32'd0);
    check("rst_dbg_ready", {31'd0, dbg_req_ready}, 32'd0);
    check("rst_if_valid", {31'd0, if_rsp_valid}, 32'd0);
    check("rst_dbg_valid", {31'd0, dbg_rsp_valid}, 32'd0);
    check("rst_if_data", if_rsp_data, 32'd0);
    check("rst_dbg_data", dbg_rsp_data, 32'd0);
    check("rst_if_err", {31'd0, if_rsp_err}, 32'd0);
    check("rst_dbg_err", {31'd0, dbg_rsp_err}, 32'd0);

    drive_edge();
    if_req_valid = 1'b0; dbg_req_valid = 1'b0;
    rst_n = 1'b1;
    drive_edge();

    // Back-to-back fetch 0x0, 0x4, 0x8 with the response consumed every cycle.
    if_rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if_req_valid = 1'b1; if_req_addr = 32'(i * 4);
      @(negedge clk);
      check("b2b_if_ready", {31'd0, if_req_ready}, 32'd1);
      check("b2b_if_valid", {31'd0, if_rsp_valid}, (i == 0) ? 32'd0 : 32'd1);
      if_q.push_back('{data: 32'(i), err: 1'b0});
      drive_edge();
    end
    if_req_valid = 1'b0;
    @(negedge clk);
    check("b2b_last_valid", {31'd0, if_rsp_valid}, 32'd1);
    drive_edge();
    @(negedge clk);
    check("b2b_drained", {31'd0, if_rsp_valid}, 32'd0);

    // Backpressure: response to 0x10 held while the next fetch is refused.
    drive_edge();
    if_rsp_ready = 1'b0; if_req_valid = 1'b1; if_req_addr = 32'h10;
    @(negedge clk);
    check("bp_first_ready", {31'd0, if_req_ready}, 32'd1);
    if_q.push_back('{data: 32'd4, err: 1'b0});
    drive_edge();
    if_req_addr = 32'h14;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_blocked_ready", {31'd0, if_req_ready}, 32'd0);
      check("bp_held_valid", {31'd0, if_rsp_valid}, 32'd1);
      check("bp_held_data", if_rsp_data, 32'd4);
      drive_edge();
    end
    if_rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", {31'd0, if_req_ready}, 32'd1);
    if_q.push_back('{data: 32'd5, err: 1'b0});
    drive_edge();
    if_req_valid = 1'b0;
    drive_edge();

    // Starvation: 4 fetch : 1 debug.
    dbg_rsp_ready = 1'b1;
    if_req_valid = 1'b1; if_req_addr = 32'h20;
    dbg_req_valid = 1'b1; dbg_req_addr = 32'h40;
    contend(10, "starve");
    drive_edge();
    if_req_valid = 1'b0; dbg_req_valid = 1'b0;
    drive_edge();

    // Error and boundary addresses on the debug port.
    dbg_req_valid = 1'b1; dbg_req_addr = 32'h6;
    @(negedge clk);
    check("err_misalign_ready", {31'd0, dbg_req_ready}, 32'd1);
    dbg_q.push_back('{data: 32'd0, err: 1'b1});
    drive_edge();
    dbg_req_addr = 32'h1000;
    @(negedge clk);
    check("err_range_ready", {31'd0, dbg_req_ready}, 32'd1);
    dbg_q.push_back('{data: 32'd0, err: 1'b1});
    drive_edge();
    dbg_req_addr = 32'hFFC;
    @(negedge clk);
    check("err_last_ready", {31'd0, dbg_req_ready}, 32'd1);
    dbg_q.push_back('{data: 32'd1023, err: 1'b0});
    drive_edge();
    dbg_req_valid = 1'b0;
    drive_edge();

    // Flush: pending fetch response dropped; pending debug response kept.
    dbg_rsp_ready = 1'b0; if_rsp_ready = 1'b0;
    dbg_req_valid = 1'b1; dbg_req_addr = 32'h44;
    @(negedge clk);
    check("fl_dbg_ready", {31'd0, dbg_req_ready}, 32'd1);
    dbg_q.push_back('{data: 32'd17, err: 1'b0});
    drive_edge();
    dbg_req_valid = 1'b0;
    if_req_valid = 1'b1; if_req_addr = 32'h30;
    @(negedge clk);
    check("fl_if_ready", {31'd0, if_req_ready}, 32'd1);
    if_q.push_back('{data: 32'd12, err: 1'b0});
    drive_edge();
    if_flush = 1'b1; if_req_addr = 32'h34;
    @(negedge clk);
    check("fl_blocked_ready", {31'd0, if_req_ready}, 32'd0);
    check("fl_pending_valid", {31'd0, if_rsp_valid}, 32'd1);
    void'(if_q.pop_back());
    drive_edge();
    if_flush = 1'b0; if_req_valid = 1'b0;
    @(negedge clk);
    check("fl_if_cleared", {31'd0, if_rsp_valid}, 32'd0);
    check("fl_dbg_kept_valid", {31'd0, dbg_rsp_valid}, 32'd1);
    check("fl_dbg_kept_data", dbg_rsp_data, 32'd17);

    // Async reset with both responses valid and the starvation counter running.
    drive_edge();
    if_req_valid = 1'b1; if_req_addr = 32'h38;
    @(negedge clk);
    check("ar_if_ready", {31'd0, if_req_ready}, 32'd1);
    if_q.push_back('{data: 32'd14, err: 1'b0});
    drive_edge();
    if_req_valid = 1'b0;
    dbg_req_valid = 1'b1; dbg_req_addr = 32'h48;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("ar_dbg_blocked", {31'd0, dbg_req_ready}, 32'd0);
      drive_edge();
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_if_valid", {31'd0, if_rsp_valid}, 32'd0);
    check("ar_if_data", if_rsp_data, 32'd0);
    check("ar_dbg_valid", {31'd0, dbg_rsp_valid}, 32'd0);
    check("ar_dbg_data", dbg_rsp_data, 32'd0);
    if_q.delete();
    dbg_q.delete();
    drive_edge();
    rst_n = 1'b1;
    if_rsp_ready = 1'b1; dbg_rsp_ready = 1'b1;
    if_req_valid = 1'b1; if_req_addr = 32'h20;
    dbg_req_valid = 1'b1; dbg_req_addr = 32'h40;
    contend(5, "ar_restart");
    drive_edge();
    if_req_valid = 1'b0; dbg_req_valid = 1'b0;
    drive_edge();
    drive_edge();

    check("if_q_empty", 32'(if_q.size()), 32'd0);
    check("dbg_q_empty", 32'(dbg_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
